// File: rtl/grad_inlet_sequencer_pkg.sv
// grad_inlet_pkg: shared state enum, default counter width and valve/pump drive struct
package grad_inlet_pkg;
  localparam int CNT_W_DEF = 16;
  typedef enum logic [2:0] {IDLE, PRIME, DOSE, FLUSH, DONE} state_t;
  typedef struct packed {
    logic valve_soln1;
    logic valve_soln2;
    logic pump_en;
  } drive_t;
  function automatic drive_t drive_of(state_t s);
    logic v;
    logic p;
    v = (s == PRIME) || (s == DOSE);
    p = (s == DOSE) || (s == FLUSH);
    return '{valve_soln1: v, valve_soln2: v, pump_en: p};
  endfunction
endpackage

// File: rtl/grad_inlet_sequencer_if.sv
// grad_inlet_sequencer_if: request handshake, abort and actuator/status signals of the sequencer
interface grad_inlet_sequencer_if #(parameter int CNT_W = grad_inlet_pkg::CNT_W_DEF);
  logic             start_valid;
  logic             start_ready;
  logic [CNT_W-1:0] dose_cyc;
  logic             abort;
  logic             valve_soln1;
  logic             valve_soln2;
  logic             pump_en;
  logic             busy;
  logic             done;
  logic             aborted;
  modport master (
    output start_valid, dose_cyc, abort,
    input  start_ready, valve_soln1, valve_soln2, pump_en, busy, done, aborted
  );
  modport slave (
    input  start_valid, dose_cyc, abort,
    output start_ready, valve_soln1, valve_soln2, pump_en, busy, done, aborted
  );
endinterface

// File: rtl/grad_inlet_sequencer_timer.sv
// grad_phase_timer: loadable down-counter that stops at zero and flags it
module grad_phase_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  input  logic             tick,
  output logic             zero
);
  logic [CNT_W-1:0] cnt;
  // load takes precedence; counting saturates at zero so it never wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= value;
    else if (tick && cnt != '0) cnt <= cnt - CNT_W'(1);
  end
  assign zero = (cnt == '0);
endmodule

// File: rtl/grad_inlet_sequencer.sv
// grad_inlet_sequencer: PRIME/DOSE/FLUSH/DONE valve and pump sequencer; FLUSH exists only with GRAD_INLET_SEQ_FLUSH_EN
module grad_inlet_sequencer
  import grad_inlet_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int PRIME_CYC = 100,
  parameter int FLUSH_CYC = 50
) (
  input logic                    clk,
  input logic                    rst_n,
  grad_inlet_sequencer_if.slave  bus
);
`ifdef GRAD_INLET_SEQ_FLUSH_EN
  localparam state_t           END_ST   = FLUSH;
  localparam logic [CNT_W-1:0] END_LOAD = CNT_W'(FLUSH_CYC - 1);
`else
  localparam state_t           END_ST   = DONE;
  localparam logic [CNT_W-1:0] END_LOAD = '0;
`endif
  localparam logic [CNT_W-1:0] PRIME_LOAD = CNT_W'(PRIME_CYC - 1);
  state_t           state, state_n;
  drive_t           drv;
  logic             rdy, busy_q, done_q, aborted_q;
  logic [CNT_W-1:0] dose_q, load_val;
  logic             load, zero, take_abort, accept;
  assign accept = bus.start_valid && rdy;
  grad_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .value (load_val),
    .tick  (state != IDLE),
    .zero  (zero)
  );
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  // next state and phase-timer load; abort beats the phase-end condition
  always_comb begin
    state_n    = state;
    load       = 1'b0;
    load_val   = '0;
    take_abort = 1'b0;
    case (state)
      IDLE: if (accept) begin
        state_n  = PRIME;
        load     = 1'b1;
        load_val = PRIME_LOAD;
      end
      PRIME, DOSE: if (bus.abort || zero) begin
        take_abort = bus.abort;
        load       = 1'b1;
        if (!bus.abort && state == PRIME && dose_q != '0) begin
          state_n  = DOSE;
          load_val = dose_q - CNT_W'(1);
        end else begin
          state_n  = END_ST;
          load_val = END_LOAD;
        end
      end
      FLUSH: if (zero) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // outputs registered from the next state so they line up with the state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drv       <= '0;
      rdy       <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      dose_q    <= '0;
    end else begin
      drv       <= drive_of(state_n);
      rdy       <= state_n == IDLE;
      busy_q    <= state_n != IDLE;
      done_q    <= state_n == DONE;
      aborted_q <= accept ? 1'b0 : aborted_q | take_abort;
      dose_q    <= accept ? bus.dose_cyc : dose_q;
    end
  end
  assign bus.valve_soln1 = drv.valve_soln1;
  assign bus.valve_soln2 = drv.valve_soln2;
  assign bus.pump_en     = drv.pump_en;
  assign bus.start_ready = rdy;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.aborted     = aborted_q;
endmodule

// File: tb/tb_grad_inlet_sequencer.sv
// tb_grad_inlet_sequencer: randomized dose requests scored against a per-sequence timing model
module tb_grad_inlet_sequencer;
  localparam int P = 4;
  localparam int F = 3;
`ifdef GRAD_INLET_SEQ_FLUSH_EN
  localparam int FE = F;
`else
  localparam int FE = 0;
`endif
  typedef struct {
    int lat;
    int vc;
    int pc;
    bit ab;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  exp_t q[$];
  grad_inlet_sequencer_if #(.CNT_W(8)) bus ();
  grad_inlet_sequencer #(.CNT_W(8), .PRIME_CYC(P), .FLUSH_CYC(F)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask
  // sequence outcome from the phase lengths: abort asserted in cycle c counts only inside PRIME/DOSE
  function automatic exp_t model(input int d, input int c);
    exp_t m;
    if (c >= 1 && c <= P + d) begin
      m.ab  = 1'b1;
      m.vc  = c;
      m.pc  = (c > P ? c - P : 0) + FE;
      m.lat = c + FE + 1;
    end else begin
      m.ab  = 1'b0;
      m.vc  = P + d;
      m.pc  = d + FE;
      m.lat = P + d + FE + 1;
    end
    return m;
  endfunction
  task automatic run_txn(input int d, input int c, input bit hold);
    int k;
    k = 0;
    while (!bus.start_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("ready_in_time", 32'(k < 200), 1);
    bus.start_valid = 1'b1;
    bus.dose_cyc    = 8'(d);
    q.push_back(model(d, c));
    @(posedge clk);
    #1;
    if (!hold) bus.start_valid = 1'b0;
    for (k = 1; k <= 300; k++) begin
      bus.abort = (k == c);
      @(negedge clk);
      if (bus.done) break;
      @(posedge clk);
      #1;
    end
    bus.abort = 1'b0;
    chk("done_in_time", 32'(k <= 300), 1);
  endtask
  task automatic reset_mid_dose();
    int k;
    k = 0;
    while (!bus.start_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    bus.start_valid = 1'b1;
    bus.dose_cyc    = 8'd5;
    @(posedge clk);
    #1;
    bus.start_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_pump_before", bus.pump_en, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_valve1", bus.valve_soln1, 0);
    chk("rst_valve2", bus.valve_soln2, 0);
    chk("rst_pump", bus.pump_en, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("rst_ready_after", bus.start_ready, 1);
    chk("rst_busy_after", bus.busy, 0);
  endtask
  // monitor: tallies each sequence while busy and scores it against the queue on done
  initial begin
    int cyc, vc, pc;
    bit after, last_ab;
    exp_t e;
    cyc = 0; vc = 0; pc = 0; after = 0; last_ab = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cyc = 0; vc = 0; pc = 0; after = 0;
      end else begin
        if (after) begin
          chk("idle_ready", bus.start_ready, 1);
          chk("idle_busy", bus.busy, 0);
          chk("idle_aborted", bus.aborted, 32'(last_ab));
          after = 0;
        end
        if (bus.busy) begin
          cyc++;
          if (bus.valve_soln1) vc++;
          if (bus.pump_en) pc++;
          chk("valves_equal", bus.valve_soln2, bus.valve_soln1);
          chk("busy_not_ready", bus.start_ready, 0);
          if (cyc == 1) chk("aborted_cleared", bus.aborted, 0);
          if (bus.done) begin
            if (q.size() == 0) begin
              fails++;
              tests++;
              $display("FAIL unexpected_done: got done with empty queue at %0t", $time);
            end else begin
              e = q.pop_front();
              chk("latency", cyc, e.lat);
              chk("valve_cycles", vc, e.vc);
              chk("pump_cycles", pc, e.pc);
              chk("aborted", bus.aborted, 32'(e.ab));
              last_ab = e.ab;
            end
            after = 1;
            cyc = 0; vc = 0; pc = 0;
          end
        end else if (bus.done) chk("done_while_idle", bus.done, 0);
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
  initial begin
    int d, c;
    bus.start_valid = 1'b0;
    bus.dose_cyc    = '0;
    bus.abort       = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ready", bus.start_ready, 1);
    chk("reset_busy", bus.busy, 0);
    chk("reset_valve1", bus.valve_soln1, 0);
    chk("reset_pump", bus.pump_en, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_aborted", bus.aborted, 0);
    rst_n = 1'b1;
    @(negedge clk);
    run_txn(5, 0, 0);
    run_txn(0, 0, 0);
    run_txn(5, 6, 0);
    run_txn(5, P + 5, 0);
    run_txn(0, P, 0);
    run_txn(2, P + 2 + 2, 0);
    run_txn(3, 0, 1);
    run_txn(3, 0, 0);
    run_txn(1, 2, 0);
    reset_mid_dose();
    for (int i = 0; i < 30; i++) begin
      d = $urandom_range(0, 6);
      c = $urandom_range(0, 1) ? $urandom_range(1, P + d + FE + 1) : 0;
      run_txn(d, c, $urandom_range(0, 3) == 0);
    end
    bus.start_valid = 1'b0;
    repeat (20) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
